// File: rtl/multi_timer.sv
// Multi-channel mm:ss timer with a memory-mapped CTRL/STATUS word per channel.
// State updates on the falling clk edge; reset is asynchronous and active-high.
module multi_timer_ch #(
    parameter int CLK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] status,
    output logic        alarm
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    logic [5:0]    sec, mins, alarm_min;
    logic          en, mode, done;
    logic          tick, at_zero;
    logic          unused_wdata;

    function automatic logic [7:0] bcd(input logic [5:0] v);
        logic [7:0] w;
        w = {2'b00, v};
        return ((w / 8'd10) << 4) | (w % 8'd10);
    endfunction

    function automatic logic [5:0] sat59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    assign tick         = en && (presc == PMAX);
    assign at_zero      = (sec == 6'd0) && (mins == 6'd0);
    assign alarm        = mode ? done : ((alarm_min != 6'd0) && (mins >= alarm_min));
    assign status       = {bcd(sec), bcd(mins), alarm, en, mode, done, 12'b0};
    assign unused_wdata = ^{wdata[31:30], wdata[23:22], wdata[15:14], wdata[7:4]};

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            sec       <= '0;
            mins      <= '0;
            alarm_min <= '0;
            en        <= 1'b0;
            mode      <= 1'b0;
            done      <= 1'b0;
        end else if (wr) begin
            // A write swallows any coincident tick; the prescaler still wraps.
            en        <= wdata[0];
            mode      <= wdata[2];
            alarm_min <= wdata[13:8];
            if (en) presc <= tick ? '0 : presc + PW'(1);
            if (wdata[1]) begin
                sec   <= '0;
                mins  <= '0;
                presc <= '0;
                done  <= 1'b0;
            end else if (wdata[3]) begin
                sec   <= sat59(wdata[21:16]);
                mins  <= sat59(wdata[29:24]);
                presc <= '0;
                done  <= 1'b0;
            end
        end else if (en && mode && at_zero) begin
            // Counting down from 00:00 finishes immediately instead of wrapping.
            done <= 1'b1;
            en   <= 1'b0;
        end else if (en) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                if (!mode) begin
                    if (sec == 6'd59) begin
                        sec  <= '0;
                        mins <= (mins == 6'd59) ? 6'd0 : mins + 6'd1;
                    end else begin
                        sec <= sec + 6'd1;
                    end
                end else if (sec == 6'd0) begin
                    sec  <= 6'd59;
                    mins <= mins - 6'd1;
                end else begin
                    sec <= sec - 6'd1;
                    if (sec == 6'd1 && mins == 6'd0) begin
                        done <= 1'b1;
                        en   <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

module multi_timer #(
    parameter int          N_CH      = 2,
    parameter int          CLK_DIV   = 100000000,
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic            w_r,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] alarm
);
    logic [N_CH-1:0]       hit;
    logic [N_CH-1:0][31:0] status;
    logic [31:0]           rd_next;

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            assign hit[k] = (addr == BASE_ADDR + 32'(4 * k));
            multi_timer_ch #(.CLK_DIV(CLK_DIV)) u_ch (
                .clk    (clk),
                .rst    (rst),
                .wr     (hit[k] & ~w_r),
                .wdata  (wdata),
                .status (status[k]),
                .alarm  (alarm[k])
            );
        end
    endgenerate

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N_CH; i++)
            if (hit[i] && w_r) rd_next = status[i];
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else     rdata <= rd_next;
    end
endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus a randomized run, checked
// against a total-seconds reference model of every channel.
module tb_multi_timer;
    localparam int          N_CH    = 2;
    localparam int          CLK_DIV = 10;
    localparam logic [31:0] BASE    = 32'h0000_8000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [31:0]     addr = 32'h0;
    logic            w_r = 1'b1;
    logic [31:0]     wdata = 32'h0;
    logic [31:0]     rdata;
    logic [N_CH-1:0] alarm;

    int checks = 0;
    int failures = 0;

    // Reference model: time held as total seconds 0..3599.
    int          m_t[N_CH], m_pc[N_CH], m_amin[N_CH];
    bit          m_en[N_CH], m_mode[N_CH], m_done[N_CH];
    logic [31:0] exp_rd;

    multi_timer #(.N_CH(N_CH), .CLK_DIV(CLK_DIV), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .w_r   (w_r),
        .wdata (wdata),
        .rdata (rdata),
        .alarm (alarm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic bit m_alarm(input int k);
        return m_mode[k] ? m_done[k] : (m_amin[k] != 0 && (m_t[k] / 60) >= m_amin[k]);
    endfunction

    function automatic logic [31:0] m_status(input int k);
        return {to_bcd(m_t[k] % 60), to_bcd(m_t[k] / 60), m_alarm(k),
                m_en[k], m_mode[k], m_done[k], 12'b0};
    endfunction

    function automatic logic [N_CH-1:0] m_alarms();
        logic [N_CH-1:0] a;
        for (int k = 0; k < N_CH; k++) a[k] = m_alarm(k);
        return a;
    endfunction

    function automatic int sat59(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    function automatic logic [31:0] ctrl(input bit en, input bit clr, input bit mode,
                                         input bit load, input int amin, input int ls,
                                         input int lm);
        return {2'b0, 6'(lm), 2'b0, 6'(ls), 2'b0, 6'(amin), 4'b0, load, mode, clr, en};
    endfunction

    task automatic m_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_t[k] = 0; m_pc[k] = 0; m_amin[k] = 0;
            m_en[k] = 0; m_mode[k] = 0; m_done[k] = 0;
        end
        exp_rd = 32'h0;
    endtask

    // Drive one bus cycle, let the falling edge happen, then advance the model.
    task automatic step(input logic [31:0] a, input logic rd, input logic [31:0] d);
        int h;
        addr = a; w_r = rd; wdata = d;
        @(negedge clk);
        #1;
        h = -1;
        for (int k = 0; k < N_CH; k++) if (a == BASE + 32'(4 * k)) h = k;
        exp_rd = (h >= 0 && rd) ? m_status(h) : 32'h0;
        for (int k = 0; k < N_CH; k++) begin
            if (h == k && !rd) begin
                if (m_en[k]) m_pc[k] = (m_pc[k] + 1) % CLK_DIV;
                m_en[k] = d[0]; m_mode[k] = d[2]; m_amin[k] = int'(d[13:8]);
                if (d[1]) begin
                    m_t[k] = 0; m_pc[k] = 0; m_done[k] = 0;
                end else if (d[3]) begin
                    m_t[k] = sat59(int'(d[21:16])) + 60 * sat59(int'(d[29:24]));
                    m_pc[k] = 0; m_done[k] = 0;
                end
            end else if (m_en[k] && m_mode[k] && m_t[k] == 0) begin
                m_done[k] = 1; m_en[k] = 0;
            end else if (m_en[k]) begin
                m_pc[k]++;
                if (m_pc[k] == CLK_DIV) begin
                    m_pc[k] = 0;
                    if (!m_mode[k]) m_t[k] = (m_t[k] + 1) % 3600;
                    else begin
                        m_t[k]--;
                        if (m_t[k] == 0) begin m_done[k] = 1; m_en[k] = 0; end
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(32'h0, 1'b1, 32'h0);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (rdata !== 32'h0 || alarm !== '0) begin
            failures++;
            $display("FAIL reset_hold rdata=%h alarm=%b required 0/0", rdata, alarm);
        end
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        m_reset();
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_read rdata=%h required 0", rdata);
        end
    endtask

    task automatic test_up_count();
        step(BASE, 1'b0, ctrl(1, 0, 0, 0, 0, 0, 0));
        idle(600);
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata[31:16] !== 16'h0001 || rdata !== exp_rd) begin
            failures++;
            $display("FAIL up_600 rdata=%h required %h (time 0001)", rdata, exp_rd);
        end
        step(BASE + 32'd4, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL up_ch1_idle rdata=%h required 0", rdata);
        end
    endtask

    task automatic test_wrap();
        step(BASE, 1'b0, ctrl(1, 0, 0, 1, 0, 58, 59));
        idle(20);
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_4000 || rdata !== exp_rd) begin
            failures++;
            $display("FAIL wrap_5959 rdata=%h required 00004000", rdata);
        end
    endtask

    task automatic test_down_done();
        step(BASE, 1'b0, ctrl(1, 0, 1, 1, 0, 2, 0));
        idle(20);
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_B000 || alarm[0] !== 1'b1) begin
            failures++;
            $display("FAIL down_done rdata=%h alarm0=%b required 0000b000/1", rdata, alarm[0]);
        end
        idle(50);
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_B000 || alarm[0] !== 1'b1) begin
            failures++;
            $display("FAIL down_hold rdata=%h alarm0=%b required 0000b000/1", rdata, alarm[0]);
        end
    endtask

    task automatic test_alarm_edge();
        step(BASE, 1'b0, ctrl(1, 0, 0, 1, 1, 59, 0));
        idle(9);
        checks++;
        if (alarm[0] !== 1'b0) begin
            failures++;
            $display("FAIL alarm_early alarm0=%b required 0", alarm[0]);
        end
        idle(1);
        checks++;
        if (alarm[0] !== 1'b1) begin
            failures++;
            $display("FAIL alarm_rise alarm0=%b required 1", alarm[0]);
        end
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0001_C000) begin
            failures++;
            $display("FAIL alarm_status rdata=%h required 0001c000", rdata);
        end
    endtask

    task automatic test_clr_load();
        step(BASE + 32'd4, 1'b0, ctrl(0, 0, 0, 1, 0, 7, 7));
        step(BASE + 32'd4, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0707_0000) begin
            failures++;
            $display("FAIL load_0707 rdata=%h required 07070000", rdata);
        end
        step(BASE + 32'd4, 1'b0, ctrl(0, 1, 0, 1, 0, 5, 5));
        step(BASE + 32'd4, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL clr_over_load rdata=%h required 0", rdata);
        end
    endtask

    task automatic test_write_tick();
        step(BASE, 1'b0, ctrl(1, 1, 0, 0, 0, 0, 0));
        idle(9);
        step(BASE, 1'b0, ctrl(1, 0, 0, 0, 0, 0, 0));
        idle(9);
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0000_4000 || rdata !== exp_rd) begin
            failures++;
            $display("FAIL write_tick_lost rdata=%h required 00004000", rdata);
        end
    endtask

    task automatic test_bad_addr();
        step(BASE, 1'b0, ctrl(0, 0, 0, 1, 0, 34, 12));
        step(BASE + 32'd8, 1'b0, ctrl(1, 1, 0, 0, 0, 0, 0));
        step(BASE + 32'd2, 1'b0, ctrl(1, 1, 0, 0, 0, 0, 0));
        step(BASE + 32'd8, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL bad_addr_read rdata=%h required 0", rdata);
        end
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h3412_0000) begin
            failures++;
            $display("FAIL bad_addr_nochange rdata=%h required 34120000", rdata);
        end
    endtask

    task automatic test_async_reset();
        step(BASE + 32'd4, 1'b0, ctrl(1, 0, 1, 1, 0, 0, 0));
        step(BASE, 1'b0, ctrl(1, 0, 0, 1, 0, 30, 0));
        idle(5);
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== exp_rd || alarm !== m_alarms()) begin
            failures++;
            $display("FAIL pre_reset rdata=%h alarm=%b required %h/%b", rdata, alarm, exp_rd, m_alarms());
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (rdata !== 32'h0 || alarm !== '0) begin
            failures++;
            $display("FAIL async_reset rdata=%h alarm=%b required 0/0", rdata, alarm);
        end
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        m_reset();
        idle(30);
        step(BASE, 1'b1, 32'h0);
        checks++;
        if (rdata !== 32'h0 || alarm !== '0) begin
            failures++;
            $display("FAIL no_resume rdata=%h alarm=%b required 0/0", rdata, alarm);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        rd;
        int          sel;
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       a = BASE;
            else if (sel < 7)  a = BASE + 32'd4;
            else if (sel == 7) a = BASE + 32'd8;
            else if (sel == 8) a = BASE + 32'd2;
            else               a = $urandom;
            rd = ($urandom_range(0, 9) != 0);
            d = $urandom;
            d[0] = ($urandom_range(0, 3) != 0);
            d[1] = ($urandom_range(0, 7) == 0);
            d[13:8] = 6'($urandom_range(0, 3));
            step(a, rd, d);
            checks++;
            if (rdata !== exp_rd || alarm !== m_alarms()) begin
                failures++;
                $display("FAIL random_%0d rdata=%h alarm=%b required %h/%b", i, rdata, alarm, exp_rd, m_alarms());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_up_count();
        test_wrap();
        test_down_done();
        test_alarm_edge();
        test_clr_load();
        test_write_tick();
        test_bad_addr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
